// File: rtl/alu_uart_sequencer.sv
// Byte-stream command sequencer: gathers operand A, operand B and opcode from the UART
// receiver, runs one ALU operation, then returns the result byte and a flags byte.
module alu_uart_sequencer #(
    parameter int DATA_WIDTH   = 8,
    parameter int OP_WIDTH     = 4,
    parameter int DONE_TIMEOUT = 255
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic                  i_rx_valid,
    output logic [DATA_WIDTH-1:0] o_operand_a,
    output logic [DATA_WIDTH-1:0] o_operand_b,
    output logic [OP_WIDTH-1:0]   o_opcode,
    output logic                  o_alu_start,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    input  logic                  i_alu_zero,
    input  logic                  i_alu_carry,
    input  logic                  i_alu_overflow,
    input  logic                  i_alu_negative,
    input  logic                  i_alu_exception,
    input  logic                  i_alu_done,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_start,
    input  logic                  i_tx_busy,
    output logic                  o_busy
);

    typedef enum logic [3:0] {
        GET_A,
        GET_B,
        GET_OP,
        EXEC,
        WAIT_DONE,
        SEND_RES,
        WAIT_RES,
        SEND_FLG,
        WAIT_FLG
    } state_t;

    localparam logic [7:0] LAST_COUNT = 8'(DONE_TIMEOUT - 1);

    state_t                state;
    logic [DATA_WIDTH-1:0] result;
    logic [4:0]            alu_flags;
    logic                  bad_op;
    logic                  timeout;
    logic                  first_wait;
    logic [7:0]            counter;
    logic [DATA_WIDTH-1:0] flag_byte;

    assign flag_byte = DATA_WIDTH'({timeout, bad_op, 1'b0, alu_flags});

    // The capture edge in WAIT_DONE also launches the result byte when the
    // transmitter is idle, so the tx pulse follows done by a single cycle.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state       <= GET_A;
            o_operand_a <= '0;
            o_operand_b <= '0;
            o_opcode    <= '0;
            o_tx_data   <= '0;
            o_alu_start <= 1'b0;
            o_tx_start  <= 1'b0;
            o_busy      <= 1'b0;
            result      <= '0;
            alu_flags   <= '0;
            bad_op      <= 1'b0;
            timeout     <= 1'b0;
            first_wait  <= 1'b0;
            counter     <= '0;
        end else begin
            o_alu_start <= 1'b0;
            o_tx_start  <= 1'b0;
            case (state)
                GET_A: begin
                    if (i_rx_valid) begin
                        o_operand_a <= i_rx_data;
                        o_busy      <= 1'b1;
                        state       <= GET_B;
                    end
                end
                GET_B: begin
                    if (i_rx_valid) begin
                        o_operand_b <= i_rx_data;
                        state       <= GET_OP;
                    end
                end
                GET_OP: begin
                    if (i_rx_valid) begin
                        if (i_rx_data[DATA_WIDTH-1:OP_WIDTH] == '0) begin
                            o_opcode    <= i_rx_data[OP_WIDTH-1:0];
                            o_alu_start <= 1'b1;
                            state       <= EXEC;
                        end else begin
                            bad_op    <= 1'b1;
                            result    <= '0;
                            alu_flags <= '0;
                            state     <= SEND_RES;
                        end
                    end
                end
                EXEC: begin
                    counter <= '0;
                    state   <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (i_alu_done) begin
                        result    <= i_alu_result;
                        alu_flags <= {i_alu_exception, i_alu_negative, i_alu_overflow,
                                      i_alu_carry, i_alu_zero};
                        if (!i_tx_busy) begin
                            o_tx_data  <= i_alu_result;
                            o_tx_start <= 1'b1;
                            first_wait <= 1'b1;
                            state      <= WAIT_RES;
                        end else begin
                            state <= SEND_RES;
                        end
                    end else begin
                        counter <= counter + 8'd1;
                        if (counter == LAST_COUNT) begin
                            timeout   <= 1'b1;
                            result    <= '0;
                            alu_flags <= '0;
                            if (!i_tx_busy) begin
                                o_tx_data  <= '0;
                                o_tx_start <= 1'b1;
                                first_wait <= 1'b1;
                                state      <= WAIT_RES;
                            end else begin
                                state <= SEND_RES;
                            end
                        end
                    end
                end
                SEND_RES: begin
                    if (!i_tx_busy) begin
                        o_tx_data  <= result;
                        o_tx_start <= 1'b1;
                        first_wait <= 1'b1;
                        state      <= WAIT_RES;
                    end
                end
                // The transmitter only raises busy the cycle after the start pulse.
                WAIT_RES: begin
                    if (first_wait) begin
                        first_wait <= 1'b0;
                    end else if (!i_tx_busy) begin
                        state <= SEND_FLG;
                    end
                end
                SEND_FLG: begin
                    if (!i_tx_busy) begin
                        o_tx_data  <= flag_byte;
                        o_tx_start <= 1'b1;
                        first_wait <= 1'b1;
                        state      <= WAIT_FLG;
                    end
                end
                WAIT_FLG: begin
                    if (first_wait) begin
                        first_wait <= 1'b0;
                    end else if (!i_tx_busy) begin
                        bad_op  <= 1'b0;
                        timeout <= 1'b0;
                        o_busy  <= 1'b0;
                        state   <= GET_A;
                    end
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= GET_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Randomized scoreboard bench for alu_uart_sequencer; the bench plays both the ALU
// and the UART transmitter and predicts every transmitted byte from the command rules.
module tb_alu_uart_sequencer;

    localparam int T = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] operand_a, operand_b, tx_data;
    logic [3:0] opcode;
    logic       alu_start, tx_start, busy;
    logic [7:0] alu_result = 8'h00;
    logic [4:0] alu_flg = 5'h00;
    logic       alu_done = 1'b0;
    logic       txm_busy = 1'b0;
    logic       hold_busy = 1'b0;
    logic       tx_busy;

    assign tx_busy = txm_busy | hold_busy;

    alu_uart_sequencer #(.DATA_WIDTH(8), .OP_WIDTH(4), .DONE_TIMEOUT(T)) dut (
        .i_clock(clock),
        .i_reset(reset),
        .i_rx_data(rx_data),
        .i_rx_valid(rx_valid),
        .o_operand_a(operand_a),
        .o_operand_b(operand_b),
        .o_opcode(opcode),
        .o_alu_start(alu_start),
        .i_alu_result(alu_result),
        .i_alu_zero(alu_flg[0]),
        .i_alu_carry(alu_flg[1]),
        .i_alu_overflow(alu_flg[2]),
        .i_alu_negative(alu_flg[3]),
        .i_alu_exception(alu_flg[4]),
        .i_alu_done(alu_done),
        .o_tx_data(tx_data),
        .o_tx_start(tx_start),
        .i_tx_busy(tx_busy),
        .o_busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] data;
        bit         is_res;
    } tx_exp_t;

    typedef struct {
        logic [7:0] res;
        logic [4:0] flg;
        int         delay;
    } plan_t;

    tx_exp_t     tx_q[$];
    logic [19:0] alu_exp_q[$];
    plan_t       plan_q[$];

    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    int   res_due = -1;
    bit   no_timing = 1'b0;
    logic prev_busy = 1'b0;
    logic prev_tx_start = 1'b0;
    logic [3:0] model_op = 4'h0;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Cycle counter and the transmitter busy level seen by each rising edge.
    initial begin
        forever begin
            @(posedge clock);
            cyc++;
            prev_busy = tx_busy;
        end
    end

    // ALU stand-in: answers each start with the planned result after the planned delay.
    initial begin
        plan_t p;
        forever begin
            @(negedge clock);
            alu_done   = 1'b0;
            alu_result = 8'($urandom);
            alu_flg    = 5'($urandom);
            if (alu_start && !reset && plan_q.size() > 0) begin
                p = plan_q.pop_front();
                if (p.delay == 0) begin
                    if (!no_timing) res_due = cyc + T + 1;
                end else begin
                    repeat (p.delay - 1) begin
                        @(negedge clock);
                        alu_result = 8'($urandom);
                        alu_flg    = 5'($urandom);
                    end
                    @(negedge clock);
                    alu_done   = 1'b1;
                    alu_result = p.res;
                    alu_flg    = p.flg;
                    if (!no_timing) res_due = cyc + 1;
                end
            end
        end
    end

    // Transmitter stand-in: busy for a few cycles after each start pulse.
    initial begin
        forever begin
            @(negedge clock);
            if (tx_start && !reset) begin
                txm_busy = 1'b1;
                repeat ($urandom_range(1, 4)) @(negedge clock);
                txm_busy = 1'b0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT starts the ALU or the transmitter.
    initial begin
        tx_exp_t e;
        logic [19:0] a;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (alu_start) begin
                    if (alu_exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("[TB] FAIL unexpected_alu_start: got start expected none");
                    end else begin
                        a = alu_exp_q.pop_front();
                        checkOutput("alu_operands", {operand_a, operand_b, opcode}, a);
                    end
                end
                if (tx_start) begin
                    checkOutput("tx_start_while_busy", prev_busy, 0);
                    checkOutput("tx_start_back_to_back", prev_tx_start, 0);
                    if (tx_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("[TB] FAIL unexpected_tx: got %0h expected none", tx_data);
                    end else begin
                        e = tx_q.pop_front();
                        checkOutput(e.is_res ? "tx_result" : "tx_flags", tx_data, e.data);
                        if (e.is_res && res_due >= 0) begin
                            checkOutput("result_latency", cyc, res_due);
                        end
                        if (e.is_res) res_due = -1;
                    end
                end
            end
            prev_tx_start = tx_start;
        end
    end

    task automatic sendByte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clock);
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((tx_q.size() != 0 || busy) && n < 300) begin
            @(negedge clock);
            n++;
        end
        checkOutput("command_complete", (n < 300), 1);
        if (n >= 300) begin
            tx_q.delete();
            alu_exp_q.delete();
            plan_q.delete();
        end
    endtask

    // One full command; expectations are queued before any byte is sent.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                                 input logic [7:0] res, input logic [4:0] flg, input int delay,
                                 input bit hold);
        bit         good;
        logic [7:0] exp_res, exp_flg;
        plan_t      p;
        good = (op[7:4] == 4'h0);
        if (good) begin
            alu_exp_q.push_back({a, b, op[3:0]});
            p.res = res;
            p.flg = flg;
            p.delay = delay;
            plan_q.push_back(p);
            model_op = op[3:0];
            exp_res = (delay == 0) ? 8'h00 : res;
            exp_flg = (delay == 0) ? 8'h80 : {3'b000, flg};
        end else begin
            exp_res = 8'h00;
            exp_flg = 8'h40;
        end
        tx_q.push_back('{data: exp_res, is_res: 1'b1});
        tx_q.push_back('{data: exp_flg, is_res: 1'b0});
        no_timing = hold;
        sendByte(a);
        sendByte(b);
        sendByte(op);
        rx_valid = 1'b0;
        checkOutput("alu_start_timing", alu_start, good);
        if (hold) begin
            hold_busy = 1'b1;
            repeat (2) sendByte(8'($urandom));
            rx_valid = 1'b0;
            repeat (18) @(negedge clock);
            hold_busy = 1'b0;
        end
        waitIdle();
        checkOutput("opcode_hold", opcode, model_op);
        no_timing = 1'b0;
    endtask

    initial begin
        logic [7:0] op;
        int d;
        repeat (2) @(negedge clock);
        checkOutput("reset_operand_a", operand_a, 0);
        checkOutput("reset_operand_b", operand_b, 0);
        checkOutput("reset_opcode", opcode, 0);
        checkOutput("reset_tx_data", tx_data, 0);
        checkOutput("reset_strobes", {alu_start, tx_start, busy}, 0);
        reset = 1'b0;
        @(negedge clock);

        applyStimulus(8'h04, 8'h05, 8'h08, 8'h09, 5'b00000, 2, 1'b0);
        applyStimulus(8'hF6, 8'h80, 8'h0A, 8'h76, 5'b00110, 1, 1'b0);
        applyStimulus(8'h10, 8'h7F, 8'h1C, 8'h00, 5'b00000, 1, 1'b0);
        applyStimulus(8'h12, 8'h34, 8'h03, 8'h55, 5'b11111, 0, 1'b0);

        sendByte(8'h11);
        sendByte(8'h22);
        rx_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        checkOutput("midreset_operands", {operand_a, operand_b}, 0);
        checkOutput("midreset_opcode_tx", {opcode, tx_data}, 0);
        checkOutput("midreset_strobes", {alu_start, tx_start, busy}, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        applyStimulus(8'h01, 8'h01, 8'h08, 8'h02, 5'b00000, 2, 1'b0);

        applyStimulus(8'h33, 8'h44, 8'h02, 8'hAB, 5'b10001, 3, 1'b1);
        applyStimulus(8'h5A, 8'hA5, 8'h01, 8'hFF, 5'b01000, 4, 1'b0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) op = {4'($urandom_range(1, 15)), 4'($urandom)};
            else op = {4'h0, 4'($urandom)};
            d = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4);
            applyStimulus(8'($urandom), 8'($urandom), op, 8'($urandom), 5'($urandom), d, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
